i2c_txn_sequencer: RTL and testbench
====================================

// Module: i2c_txn_sequencer
// PURPOSE
//  Sequences the OpenCores I2C master core's byte-level register interface so that
//  a requester can issue complete single-byte register writes and reads (START,
//  addr, reg, data, STOP) to the gesture/light sensor. Sits between the requester
//  and the i2c_opencores register port. After reset it programs the prescaler and
//  enables the core, then serves one transaction at a time.
// PARAMETERS
//  PRESCALE   16'd99    value written to PRERlo/PRERhi (50 MHz -> 100 kHz SCL)
//  TIMEOUT    100000    max clk_clk cycles polling SR.TIP per byte before abort
// PORTS
//  clk_clk        in   1  system clock
//  reset_reset_n  in   1  asynchronous active-low reset
//  req_valid      in   1  transaction request
//  req_ready      out  1  high in IDLE only; transfer on req_valid&req_ready
//  req_rnw        in   1  1 = read, 0 = write
//  req_dev        in   7  7-bit device address
//  req_reg        in   8  device register address
//  req_wdata      in   8  write data (ignored on read)
//  rsp_valid      out  1  one-cycle pulse at transaction end
//  rsp_rdata      out  8  read byte, valid with rsp_valid (0 on write/error)
//  rsp_err        out  2  0 ok, 1 NACK, 2 timeout; valid with rsp_valid
//  init_done      out  1  high once core is configured and enabled
//  i2c_adr        out  3  core register address
//  i2c_dat_o      out  8  core write data
//  i2c_dat_i      in   8  core read data
//  i2c_we         out  1  write strobe qualifier
//  i2c_stb        out  1  cycle/strobe to core
//  i2c_ack        in   1  core access acknowledge
// BEHAVIOUR
//  Reset: all outputs 0; state INIT_PLO; req inputs ignored until init_done.
//  Bus access: stb/we/adr/dat held stable until ack; stb drops cycle after ack;
//   never two accesses back-to-back without one idle cycle. Read data taken at ack.
//  Init: wr adr0=PRESCALE[7:0], adr1=PRESCALE[15:8], adr2(CTR)=0x80 -> init_done=1, IDLE.
//  Accept: in IDLE, req_valid latches all req_* fields; req_ready drops next cycle.
//  Byte step = wr TXR(adr3), wr CR(adr4), then poll rd SR(adr4) until bit1(TIP)=0.
//   After poll, SR bit7(RxACK)=1 on a write byte -> NACK abort.
//  Write txn: {dev,0} CR=0x90; reg CR=0x10; wdata CR=0x50 -> DONE.
//  Read txn:  {dev,0} CR=0x90; reg CR=0x10; {dev,1} CR=0x90; CR=0x68 (RD,NACK,STO),
//   poll TIP, rd RXR(adr3) -> rsp_rdata -> DONE. No RxACK check after RD byte.
//  NACK abort: wr CR=0x40 (STO), poll TIP, then rsp_err=1.
//  Timeout: poll counter reset per byte; reaching TIMEOUT -> wr CR=0x40 (no poll)
//   -> rsp_err=2. A timeout during init leaves init_done=0 and retries init.
//  DONE: rsp_valid=1 for exactly one cycle with rdata/err, then IDLE.
//  Latency (ack same cycle as stb+1, TIP clears immediately): fixed, checked in TB.
//  Reset mid-transaction: immediate return to INIT_PLO, stb=0, no STOP issued.
//  req_valid held high in DONE is not accepted until IDLE.
// STRUCTURE
//  Package i2c_oc_pkg: register addresses (PRER_LO=0,PRER_HI=1,CTR=2,TXR_RXR=3,
//   CR_SR=4), CR bits (STA=0x80,STO=0x40,RD=0x20,WR=0x10,ACK=0x08), SR bits
//   (RXACK=7,TIP=1), CTR_EN=0x80, rsp_err encoding, state enum.
//  Sub-module i2c_reg_access: single read/write handshake on the core port
//   (start/addr/wdata in, done/rdata out); sequencer FSM sits above it.
// TESTING (core BFM: ack 1 cycle after stb, TIP busy N cycles, RxACK programmable)
//  1 reset release -> writes 0x63@0, 0x00@1, 0x80@2 in order; init_done=1; stb low.
//  2 write dev 0x39 reg 0x80 data 0x45 -> TXR 0x72/CR 0x90, 0x80/0x10, 0x45/0x50;
//    rsp_valid 1 cycle, err 0.
//  3 read dev 0x39 reg 0xAE, BFM RXR=0x1C -> TXR 0x72,0xAE,0x73, CR 0x68; rdata 0x1C.
//  4 NACK on address byte (RxACK=1) -> CR 0x40 written, no reg byte, err=1, rdata 0.
//  5 TIP stuck with TIMEOUT=64 -> abort after 64 poll cycles, CR 0x40, err=2.
//  6 reset asserted mid-read -> outputs 0 at once; re-init sequence; next txn ok.

Source files
------------

// File: rtl/i2c_oc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_oc_pkg
// Brief    : OpenCores I2C master register map, command bits and sequencer states
// Revision : 1.0  initial release
// ============================================================================
package i2c_oc_pkg;

    // Core register addresses
    localparam logic [2:0] PRER_LO = 3'd0;
    localparam logic [2:0] PRER_HI = 3'd1;
    localparam logic [2:0] CTR     = 3'd2;
    localparam logic [2:0] TXR_RXR = 3'd3;
    localparam logic [2:0] CR_SR   = 3'd4;

    localparam logic [7:0] CR_STA = 8'h80;
    localparam logic [7:0] CR_STO = 8'h40;
    localparam logic [7:0] CR_RD  = 8'h20;
    localparam logic [7:0] CR_WR  = 8'h10;
    localparam logic [7:0] CR_ACK = 8'h08;

    localparam int SR_RXACK = 7;
    localparam int SR_TIP   = 1;

    localparam logic [7:0] CTR_EN = 8'h80;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    typedef enum logic [3:0] {
        S_INIT_PLO  = 4'd0,
        S_INIT_PHI  = 4'd1,
        S_INIT_CTR  = 4'd2,
        S_IDLE      = 4'd3,
        S_TXR       = 4'd4,
        S_CR        = 4'd5,
        S_POLL      = 4'd6,
        S_STOP_CR   = 4'd7,
        S_STOP_POLL = 4'd8,
        S_RXR       = 4'd9,
        S_DONE      = 4'd10
    } seq_state_t;

    // Byte steps: 0 = addr+W, 1 = register, 2 = wdata or addr+R, 3 = read byte
    function automatic logic [7:0] cr_byte(input logic [1:0] step, input logic rnw);
        logic [7:0] v;
        v = CR_WR;
        case (step)
            2'd0:    v = CR_STA | CR_WR;
            2'd1:    v = CR_WR;
            2'd2:    v = rnw ? (CR_STA | CR_WR) : (CR_STO | CR_WR);
            default: v = CR_STO | CR_RD | CR_ACK;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_reg_access.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_access
// Brief    : One strobe/ack handshake on the I2C core register port per start
// Revision : 1.0  initial release
// ============================================================================
module i2c_reg_access (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_we,
    input  logic [2:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic [2:0] o_i2c_adr,
    output logic [7:0] o_i2c_dat,
    input  logic [7:0] i_i2c_dat,
    output logic       o_i2c_we,
    output logic       o_i2c_stb,
    input  logic       i_i2c_ack
);

    logic       r_stb;
    logic       r_we;
    logic [2:0] r_adr;
    logic [7:0] r_dat;
    logic       r_done;
    logic [7:0] r_rdata;

    // done is issued the cycle stb is already low, giving the mandatory idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= 3'd0;
            r_dat   <= 8'd0;
            r_done  <= 1'b0;
            r_rdata <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (r_stb) begin
                if (i_i2c_ack) begin
                    r_stb   <= 1'b0;
                    r_done  <= 1'b1;
                    r_rdata <= i_i2c_dat;
                end
            end else if (i_start) begin
                r_stb <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_addr;
                r_dat <= i_wdata;
            end
        end
    end

    assign o_done    = r_done;
    assign o_rdata   = r_rdata;
    assign o_i2c_adr = r_adr;
    assign o_i2c_dat = r_dat;
    assign o_i2c_we  = r_we;
    assign o_i2c_stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_sequencer
// Brief    : Runs complete single-byte register writes/reads through the
//            OpenCores I2C master after configuring its prescaler
// Revision : 1.0  initial release
// ============================================================================
module i2c_txn_sequencer #(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter int          TIMEOUT  = 100000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       init_done,
    output logic [2:0] i2c_adr,
    output logic [7:0] i2c_dat_o,
    input  logic [7:0] i2c_dat_i,
    output logic       i2c_we,
    output logic       i2c_stb,
    input  logic       i2c_ack
);
    import i2c_oc_pkg::*;

    localparam int                TCNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] C_TMO_LAST = TCNT_W'(TIMEOUT - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              r_wait;
    logic              r_rnw;
    logic [6:0]        r_dev;
    logic [7:0]        r_reg;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic [1:0]        r_step;
    logic [1:0]        r_err;
    logic              r_init_done;
    logic [TCNT_W-1:0] r_tcnt;

    logic              w_start;
    logic              w_we;
    logic [2:0]        w_addr;
    logic [7:0]        w_wdata;
    logic              w_done;
    logic [7:0]        w_rdata;
    logic              w_tip;
    logic              w_rxack;
    logic              w_tmo;
    logic [7:0]        w_txr_byte;
    logic              w_accept;
    logic              w_step_inc;
    logic              w_err_load;
    logic [1:0]        w_err_val;
    logic              w_rdata_load;
    logic              w_tcnt_clr;

    i2c_reg_access u_reg_access (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .i_start   (w_start),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .o_done    (w_done),
        .o_rdata   (w_rdata),
        .o_i2c_adr (i2c_adr),
        .o_i2c_dat (i2c_dat_o),
        .i_i2c_dat (i2c_dat_i),
        .o_i2c_we  (i2c_we),
        .o_i2c_stb (i2c_stb),
        .i_i2c_ack (i2c_ack)
    );

    assign w_tip   = w_rdata[SR_TIP];
    assign w_rxack = w_rdata[SR_RXACK];
    assign w_tmo   = (r_tcnt >= C_TMO_LAST);
    assign w_start = (r_state != S_IDLE) && (r_state != S_DONE) && !r_wait;

    always_comb begin
        w_txr_byte = r_reg;
        case (r_step)
            2'd0:    w_txr_byte = {r_dev, 1'b0};
            2'd1:    w_txr_byte = r_reg;
            default: w_txr_byte = r_rnw ? {r_dev, 1'b1} : r_wdata;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_INIT_PLO;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_we         = 1'b1;
        w_addr       = CR_SR;
        w_wdata      = 8'd0;
        w_accept     = 1'b0;
        w_step_inc   = 1'b0;
        w_err_load   = 1'b0;
        w_err_val    = ERR_OK;
        w_rdata_load = 1'b0;
        w_tcnt_clr   = 1'b0;
        case (r_state)
            S_INIT_PLO: begin
                w_addr  = PRER_LO;
                w_wdata = PRESCALE[7:0];
                if (w_done) w_state_nxt = S_INIT_PHI;
            end
            S_INIT_PHI: begin
                w_addr  = PRER_HI;
                w_wdata = PRESCALE[15:8];
                if (w_done) w_state_nxt = S_INIT_CTR;
            end
            S_INIT_CTR: begin
                w_addr  = CTR;
                w_wdata = CTR_EN;
                if (w_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_TXR;
                end
            end
            S_TXR: begin
                w_addr  = TXR_RXR;
                w_wdata = w_txr_byte;
                if (w_done) w_state_nxt = S_CR;
            end
            S_CR: begin
                w_wdata = cr_byte(r_step, r_rnw);
                if (w_done) begin
                    w_tcnt_clr  = 1'b1;
                    w_state_nxt = S_POLL;
                end
            end
            S_POLL: begin
                w_we = 1'b0;
                if (w_done) begin
                    if (w_tip) begin
                        if (w_tmo) begin
                            w_err_load  = 1'b1;
                            w_err_val   = ERR_TMO;
                            w_state_nxt = S_STOP_CR;
                        end
                    end else if (r_step == 2'd3) begin
                        w_state_nxt = S_RXR;
                    end else if (w_rxack) begin
                        w_err_load  = 1'b1;
                        w_err_val   = ERR_NACK;
                        w_state_nxt = S_STOP_CR;
                    end else if (r_step == 2'd2 && !r_rnw) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_step_inc  = 1'b1;
                        // the read byte needs no TXR load, only a command
                        w_state_nxt = (r_step == 2'd2) ? S_CR : S_TXR;
                    end
                end
            end
            S_STOP_CR: begin
                w_wdata = CR_STO;
                if (w_done) begin
                    w_tcnt_clr  = 1'b1;
                    w_state_nxt = (r_err == ERR_TMO) ? S_DONE : S_STOP_POLL;
                end
            end
            S_STOP_POLL: begin
                w_we = 1'b0;
                if (w_done && (!w_tip || w_tmo)) w_state_nxt = S_DONE;
            end
            S_RXR: begin
                w_we   = 1'b0;
                w_addr = TXR_RXR;
                if (w_done) begin
                    w_rdata_load = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT_PLO;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wait      <= 1'b0;
            r_rnw       <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_wdata     <= 8'd0;
            r_rdata     <= 8'd0;
            r_step      <= 2'd0;
            r_err       <= ERR_OK;
            r_init_done <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            if (w_done)       r_wait <= 1'b0;
            else if (w_start) r_wait <= 1'b1;
            if (w_accept) begin
                r_rnw   <= req_rnw;
                r_dev   <= req_dev;
                r_reg   <= req_reg;
                r_wdata <= req_wdata;
                r_step  <= 2'd0;
                r_err   <= ERR_OK;
                r_rdata <= 8'd0;
            end
            if (w_step_inc)   r_step  <= r_step + 2'd1;
            if (w_err_load)   r_err   <= w_err_val;
            if (w_rdata_load) r_rdata <= w_rdata;
            if (w_tcnt_clr)
                r_tcnt <= '0;
            else if ((r_state == S_POLL || r_state == S_STOP_POLL) && !w_tmo)
                r_tcnt <= r_tcnt + TCNT_W'(1);
            if (r_state == S_INIT_CTR && w_done) r_init_done <= 1'b1;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_txn_sequencer
// Brief    : Directed bench for i2c_txn_sequencer with an I2C core register model
// Revision : 1.0  initial release
// ============================================================================
module tb_i2c_txn_sequencer;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rnw = 1'b0;
    logic [6:0] req_dev = 7'd0;
    logic [7:0] req_reg = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       init_done;
    logic [2:0] i2c_adr;
    logic [7:0] i2c_dat_o;
    logic [7:0] i2c_dat_i;
    logic       i2c_we;
    logic       i2c_stb;
    logic       i2c_ack;

    int passed = 0;
    int total  = 0;

    // core model state
    logic [10:0] wlog[$];
    int          sr_reads  = 0;
    int          tip_left  = 0;
    int          tip_n     = 0;
    bit          tip_stuck = 1'b0;
    bit          rxack     = 1'b0;
    logic [7:0]  rxr       = 8'h00;

    i2c_txn_sequencer #(.PRESCALE(16'd99), .TIMEOUT(64)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rnw       (req_rnw),
        .req_dev       (req_dev),
        .req_reg       (req_reg),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .init_done     (init_done),
        .i2c_adr       (i2c_adr),
        .i2c_dat_o     (i2c_dat_o),
        .i2c_dat_i     (i2c_dat_i),
        .i2c_we        (i2c_we),
        .i2c_stb       (i2c_stb),
        .i2c_ack       (i2c_ack)
    );

    always #5 clk_clk = ~clk_clk;

    // ack one cycle after stb, single pulse; writes logged as {adr,dat}
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            i2c_ack   <= 1'b0;
            i2c_dat_i <= 8'h00;
            tip_left  = 0;
        end else begin
            i2c_ack <= 1'b0;
            if (i2c_stb && !i2c_ack) begin
                i2c_ack <= 1'b1;
                if (i2c_we) begin
                    wlog.push_back({i2c_adr, i2c_dat_o});
                    if (i2c_adr == 3'd4) tip_left = tip_n;
                end else if (i2c_adr == 3'd4) begin
                    sr_reads++;
                    i2c_dat_i <= {rxack, 5'b0, (tip_stuck || tip_left != 0), 1'b0};
                    if (tip_left != 0) tip_left--;
                end else begin
                    i2c_dat_i <= rxr;
                end
            end
        end
    end

    task automatic wait_init(output bit ok);
        int n;
        n = 0;
        while (!init_done && n < 300) begin
            @(posedge clk_clk); #1;
            n++;
        end
        ok = init_done;
    endtask

    task automatic do_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd,
                          output logic [1:0] er, output bit seen, output bit pulse_ok);
        int n;
        @(negedge clk_clk);
        req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        @(posedge clk_clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk_clk); #1;
            lat++;
        end
        seen = rsp_valid;
        rd   = rsp_rdata;
        er   = rsp_err;
        @(posedge clk_clk); #1;
        pulse_ok = seen && !rsp_valid;
    endtask

    task automatic test_reset();
        bit          ok;
        logic [10:0] exp[$];
        exp = '{11'h063, 11'h100, 11'h280};
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, init_done, i2c_stb, i2c_we, i2c_adr, i2c_dat_o} !== 26'd0)
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%0d rdata=%h init=%b stb=%b, want all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, init_done, i2c_stb);
        else passed++;
        wlog.delete();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        wait_init(ok);
        total++;
        if (ok !== 1'b1) $display("FAIL init_done: got %b want 1", ok);
        else passed++;
        total++;
        if (wlog.size() != exp.size()) $display("FAIL init_count: got %0d want %0d", wlog.size(), exp.size());
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) $display("FAIL init_write%0d: got %h want %h", i, wlog[i], exp[i]);
            else passed++;
        end
        total++;
        if ({i2c_stb, req_ready} !== 2'b01) $display("FAIL init_idle: got stb=%b ready=%b want 0/1", i2c_stb, req_ready);
        else passed++;
    endtask

    task automatic test_write();
        int          lat;
        logic [7:0]  rd;
        logic [1:0]  er;
        bit          seen, pulse_ok;
        logic [10:0] exp[$];
        exp = '{11'h372, 11'h490, 11'h380, 11'h410, 11'h345, 11'h450};
        wlog.delete();
        do_txn(1'b0, 7'h39, 8'h80, 8'h45, lat, rd, er, seen, pulse_ok);
        total++;
        if (!seen) $display("FAIL wr_rsp: rsp_valid not seen within bound");
        else passed++;
        total++;
        if (lat != 36) $display("FAIL wr_latency: got %0d want 36", lat);
        else passed++;
        total++;
        if ({er, rd} !== 10'd0) $display("FAIL wr_result: got err=%0d rdata=%h want 0/00", er, rd);
        else passed++;
        total++;
        if (!pulse_ok) $display("FAIL wr_pulse: rsp_valid not a single-cycle pulse");
        else passed++;
        total++;
        if (wlog.size() != exp.size()) $display("FAIL wr_count: got %0d want %0d", wlog.size(), exp.size());
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) $display("FAIL wr_write%0d: got %h want %h", i, wlog[i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_read();
        int          lat;
        logic [7:0]  rd;
        logic [1:0]  er;
        bit          seen, pulse_ok;
        logic [10:0] exp[$];
        exp = '{11'h372, 11'h490, 11'h3AE, 11'h410, 11'h373, 11'h490, 11'h468};
        wlog.delete();
        rxr = 8'h1C;
        do_txn(1'b1, 7'h39, 8'hAE, 8'h00, lat, rd, er, seen, pulse_ok);
        total++;
        if (!seen) $display("FAIL rd_rsp: rsp_valid not seen within bound");
        else passed++;
        total++;
        if (lat != 48) $display("FAIL rd_latency: got %0d want 48", lat);
        else passed++;
        total++;
        if (rd !== 8'h1C || er !== 2'd0) $display("FAIL rd_result: got rdata=%h err=%0d want 1c/0", rd, er);
        else passed++;
        total++;
        if (wlog.size() != exp.size()) $display("FAIL rd_count: got %0d want %0d", wlog.size(), exp.size());
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) $display("FAIL rd_write%0d: got %h want %h", i, wlog[i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_nack();
        int          lat;
        logic [7:0]  rd;
        logic [1:0]  er;
        bit          seen, pulse_ok;
        logic [10:0] exp[$];
        exp = '{11'h372, 11'h490, 11'h440};
        wlog.delete();
        rxack = 1'b1;
        do_txn(1'b0, 7'h39, 8'h10, 8'h55, lat, rd, er, seen, pulse_ok);
        rxack = 1'b0;
        total++;
        if (!seen || er !== 2'd1 || rd !== 8'h00)
            $display("FAIL nack_result: got seen=%b err=%0d rdata=%h want 1/1/00", seen, er, rd);
        else passed++;
        total++;
        if (wlog.size() != exp.size()) $display("FAIL nack_count: got %0d want %0d", wlog.size(), exp.size());
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) $display("FAIL nack_write%0d: got %h want %h", i, wlog[i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        int          lat;
        logic [7:0]  rd;
        logic [1:0]  er;
        bit          seen, pulse_ok;
        logic [10:0] exp[$];
        exp = '{11'h372, 11'h490, 11'h440};
        wlog.delete();
        sr_reads  = 0;
        tip_stuck = 1'b1;
        do_txn(1'b0, 7'h39, 8'h80, 8'h45, lat, rd, er, seen, pulse_ok);
        tip_stuck = 1'b0;
        total++;
        if (!seen || er !== 2'd2) $display("FAIL tmo_result: got seen=%b err=%0d want 1/2", seen, er);
        else passed++;
        // 64 poll cycles at 4 cycles per SR read
        total++;
        if (sr_reads != 16) $display("FAIL tmo_polls: got %0d SR reads want 16", sr_reads);
        else passed++;
        total++;
        if (lat != 76) $display("FAIL tmo_latency: got %0d want 76", lat);
        else passed++;
        total++;
        if (wlog.size() != exp.size()) $display("FAIL tmo_count: got %0d want %0d", wlog.size(), exp.size());
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) $display("FAIL tmo_write%0d: got %h want %h", i, wlog[i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int          n, lat;
        logic [7:0]  rd;
        logic [1:0]  er;
        bit          ok, seen, pulse_ok;
        logic [10:0] exp[$];
        exp = '{11'h063, 11'h100, 11'h280};
        wlog.delete();
        @(negedge clk_clk);
        req_valid = 1'b1; req_rnw = 1'b1; req_dev = 7'h39; req_reg = 8'hAE;
        @(posedge clk_clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (wlog.size() < 4 && n < 200) begin
            @(posedge clk_clk); #1;
            n++;
        end
        @(negedge clk_clk); #2;
        reset_reset_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, init_done, i2c_stb, i2c_we, i2c_adr, i2c_dat_o} !== 26'd0)
            $display("FAIL midrst_outputs: got ready=%b valid=%b init=%b stb=%b we=%b adr=%0d, want all 0",
                     req_ready, rsp_valid, init_done, i2c_stb, i2c_we, i2c_adr);
        else passed++;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        wlog.delete();
        reset_reset_n = 1'b1;
        wait_init(ok);
        total++;
        if (!ok || wlog.size() != exp.size())
            $display("FAIL midrst_reinit: got init=%b writes=%0d want 1/3", ok, wlog.size());
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) $display("FAIL midrst_write%0d: got %h want %h", i, wlog[i], exp[i]);
            else passed++;
        end
        do_txn(1'b0, 7'h39, 8'h81, 8'hA5, lat, rd, er, seen, pulse_ok);
        total++;
        if (!seen || er !== 2'd0 || lat != 36)
            $display("FAIL midrst_txn: got seen=%b err=%0d lat=%0d want 1/0/36", seen, er, lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
